mips_mc_control: RTL and testbench

- Multi-cycle control unit for the next-generation MIPS core; replaces the single-cycle combinational decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives the multi-cycle datapath's enables and muxes.
- Stalls on a variable-latency memory handshake and traps illegal opcodes and memory timeouts.
- Sits beside the datapath under the mips top and receives OpCode from the instruction register.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mips_mem_wait_timer.sv | 28 ++
 rtl/mips_mc_control.sv | 183 ++++++++++++++++++
 tb/tb_mips_mc_control.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, datapath
// mux selects, FSM states and trap causes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_SHIMM = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_REXEC, S_RWB, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_BEQ, S_JUMP, S_ADDIEX, S_ADDIWB, S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } cause_e;

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags a timeout
// once MAX_WAIT of them have elapsed and the memory is still not ready.
module mips_mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max  = (r_cnt == CW'(MAX_WAIT));
  // A ready in the limit cycle completes the access instead of trapping.
  assign o_timeout = i_active && !i_ready && w_at_max;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_cnt <= '0;
    else if (!i_active || i_ready) r_cnt <= '0;
    else if (!w_at_max)            r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, traps illegal opcodes and memory timeouts.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 4,
  parameter int MAX_WAIT = 15,
  parameter int RET_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    OpCode,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [RET_W-1:0]   retired
);

  state_e            r_state, w_next;
  cause_e            r_cause, w_cause_nxt;
  logic [RET_W-1:0]  r_retired;
  logic              w_retire, w_mem_active, w_timeout;
  logic              w_unused_zero;

  // Branch qualification by Zero happens in the datapath.
  assign w_unused_zero = Zero;

  assign w_mem_active = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                        (r_state == S_MEMWR);

  mips_mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_active (w_mem_active),
    .i_ready  (mem_ready),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cause   <= CAUSE_NONE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_nxt;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cause_nxt = r_cause;
    w_retire    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_W'(ALUOP_ADD);
    PCSource    = PCSRC_ALU;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
        else if (w_timeout) begin
          w_next      = S_TRAP;
          w_cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_SHIMM;
        if      (OpCode == OP_W'(OP_RTYPE))                           w_next = S_REXEC;
        else if (OpCode == OP_W'(OP_LW) || OpCode == OP_W'(OP_SW))    w_next = S_MEMADR;
        else if (OpCode == OP_W'(OP_BEQ))                             w_next = S_BEQ;
        else if (OpCode == OP_W'(OP_J))                               w_next = S_JUMP;
        else if (OpCode == OP_W'(OP_ADDI))                            w_next = S_ADDIEX;
        else begin
          w_next      = S_TRAP;
          w_cause_nxt = CAUSE_ILLEGAL;
        end
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(ALUOP_FUNCT);
        w_next  = S_RWB;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = (OpCode == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
        else if (w_timeout) begin
          w_next      = S_TRAP;
          w_cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_timeout) begin
          w_next      = S_TRAP;
          w_cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_W'(ALUOP_SUB);
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_IDLE;
    endcase
  end

  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_cause;
  assign retired    = r_retired;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for the multi-cycle control FSM: walks each instruction class,
// memory stalls, timeout and illegal-opcode traps, and async reset mid-access.
module tb_mips_mc_control;

  logic        clk, reset, Zero, mem_ready;
  logic [5:0]  OpCode;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource, trap_cause;
  logic [3:0]  ALUOp;
  logic        trap;
  logic [31:0] retired;
  logic [17:0] ctl;
  int          npass = 0;
  int          ntotal = 0;

  mips_mc_control dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // bits: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA
  task automatic chk_ctl(input string tag, input logic [9:0] bits, input logic [1:0] asb,
                         input logic [3:0] aop, input logic [1:0] pcs);
    chk(tag, {14'd0, ctl}, {14'd0, bits, asb, aop, pcs});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; OpCode = 6'h00; Zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk_ctl("idle_ctl", 10'b0, 2'd0, 4'd0, 2'd0);
    chk("idle_retired", retired, 32'd0);
    chk("idle_trap", {30'd0, trap_cause}, 32'd0);
    reset = 1'b1;

    // R-type, zero wait states
    step(); chk_ctl("r_fetch",  10'b1001010000, 2'd1, 4'd0, 2'd0);
    step(); chk_ctl("r_decode", 10'b0000000000, 2'd3, 4'd0, 2'd0);
    step(); chk_ctl("r_exec",   10'b0000000001, 2'd0, 4'd2, 2'd0);
    step(); chk_ctl("r_wb",     10'b0000000110, 2'd0, 4'd0, 2'd0);
    chk("r_wb_retired", retired, 32'd0);
    OpCode = 6'h23;
    step(); chk("r_retired", retired, 32'd1);
    chk_ctl("lw_fetch", 10'b1001010000, 2'd1, 4'd0, 2'd0);

    // lw with 3 not-ready cycles in MEMRD
    step(); chk_ctl("lw_decode", 10'b0000000000, 2'd3, 4'd0, 2'd0);
    step(); chk_ctl("lw_memadr", 10'b0000000001, 2'd2, 4'd0, 2'd0);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk_ctl($sformatf("lw_memrd%0d", i), 10'b0011000000, 2'd0, 4'd0, 2'd0);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    chk_ctl("lw_memwb", 10'b0000001010, 2'd0, 4'd0, 2'd0);
    OpCode = 6'h08;
    step(); chk("lw_retired", retired, 32'd2);

    // addi with a stalled fetch: IRWrite/PCWrite follow mem_ready
    mem_ready = 1'b0; #1;
    chk_ctl("addi_fetch_wait", 10'b0001000000, 2'd1, 4'd0, 2'd0);
    step(); chk_ctl("addi_fetch_wait2", 10'b0001000000, 2'd1, 4'd0, 2'd0);
    mem_ready = 1'b1; #1;
    chk_ctl("addi_fetch_rdy", 10'b1001010000, 2'd1, 4'd0, 2'd0);
    step(); step(); chk_ctl("addi_ex", 10'b0000000001, 2'd2, 4'd0, 2'd0);
    step(); chk_ctl("addi_wb", 10'b0000000010, 2'd0, 4'd0, 2'd0);
    OpCode = 6'h04; Zero = 1'b1;
    step(); chk("addi_retired", retired, 32'd3);

    // beq then j, 3 cycles each
    step(); step(); chk_ctl("beq_exec", 10'b0100000001, 2'd0, 4'd1, 2'd1);
    OpCode = 6'h02;
    step(); chk("beq_retired", retired, 32'd4);
    chk_ctl("j_fetch", 10'b1001010000, 2'd1, 4'd0, 2'd0);
    step(); step(); chk_ctl("j_exec", 10'b1000000000, 2'd0, 4'd0, 2'd2);
    OpCode = 6'h23;
    step(); chk("j_retired", retired, 32'd5);

    // lw aborted by async reset mid-MEMRD
    step(); step(); mem_ready = 1'b0;
    step(); chk_ctl("abort_memrd", 10'b0011000000, 2'd0, 4'd0, 2'd0);
    #2 reset = 1'b0; #1;
    chk_ctl("abort_ctl", 10'b0, 2'd0, 4'd0, 2'd0);
    chk("abort_retired", retired, 32'd0);
    step(); reset = 1'b1; mem_ready = 1'b1; OpCode = 6'h2B;
    chk_ctl("abort_idle", 10'b0, 2'd0, 4'd0, 2'd0);
    step(); chk_ctl("abort_fetch", 10'b1001010000, 2'd1, 4'd0, 2'd0);

    // sw with memory never ready: MAX_WAIT+1 cycles in MEMWR, then TRAP
    step(); step(); mem_ready = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 15)
        chk_ctl($sformatf("sw_memwr%0d", i), 10'b0010100000, 2'd0, 4'd0, 2'd0);
      chk($sformatf("sw_notrap%0d", i), {31'd0, trap}, 32'd0);
      step();
    end
    chk("sw_trap", {31'd0, trap}, 32'd1);
    chk("sw_cause", {30'd0, trap_cause}, 32'd2);
    chk_ctl("sw_trap_ctl", 10'b0, 2'd0, 4'd0, 2'd0);
    chk("sw_retired", retired, 32'd0);

    // illegal opcode traps from DECODE and stays there
    reset = 1'b0; #1;
    chk("rst_cause_clr", {30'd0, trap_cause}, 32'd0);
    step(); reset = 1'b1; mem_ready = 1'b1; OpCode = 6'h3F;
    step(); step(); chk_ctl("ill_decode", 10'b0, 2'd3, 4'd0, 2'd0);
    step(); chk("ill_trap", {31'd0, trap}, 32'd1);
    chk("ill_cause", {30'd0, trap_cause}, 32'd1);
    chk_ctl("ill_ctl", 10'b0, 2'd0, 4'd0, 2'd0);
    for (int i = 0; i < 100; i++) step();
    chk("ill_trap_held", {31'd0, trap}, 32'd1);
    chk("ill_cause_held", {30'd0, trap_cause}, 32'd1);
    chk_ctl("ill_ctl_held", 10'b0, 2'd0, 4'd0, 2'd0);
    chk("ill_retired", retired, 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
